immediate_generator: RTL and testbench
======================================

// Module: immediate_generator
// PURPOSE
//  RV32I immediate generator for the decode stage.
//  Extracts the immediate field from a 32-bit instruction word.
//  The field format is selected by imm_sel (I, shamt, I-unsigned, S, B, U, J).
//  The result is sign- or zero-extended to 32 bits and registered into imm_out.
//  Sits between the instruction register and the ALU operand-B / branch-target muxes.
// PARAMETERS
//  XLEN      32   datapath / output width (only 32 supported)
//  ILEN      32   instruction width (only 32 supported)
// PORTS
//  One clock; reset is asynchronous and active-low.
//  clk      in   1     rising-edge clock
//  rst_n    in   1     asynchronous active-low reset
//  ins      in   32    instruction word
//  imm_sel  in   3     immediate format select (encoding below)
//  imm_out  out  32    extended immediate, registered
// BEHAVIOUR
//  - imm_sel encoding and result (s = ins[31], sign-extended):
//    000 IMM_I   : {{20{s}}, ins[31:20]}
//    001 IMM_SH  : {27'b0, ins[24:20]}  (shift amount, zero-ext)
//    010 IMM_IU  : {20'b0, ins[31:20]}  (unsigned 12-bit, e.g. sltiu/CSR)
//    011 IMM_S   : {{20{s}}, ins[31:25], ins[11:7]}
//    100 IMM_B   : {{19{s}}, s, ins[7], ins[30:25], ins[11:8], 1'b0}
//    101 IMM_U   : {ins[31:12], 12'b0}
//    110 IMM_J   : {{11{s}}, s, ins[19:12], ins[20], ins[30:21], 1'b0}
//    111 IMM_NONE: 32'h0000_0000
//  - Next value is computed combinationally from ins and imm_sel.
//  - imm_out captures the next value on every rising clk edge.
//  - Latency is exactly 1 cycle. There is no enable and no stall hold.
//  - Reset: rst_n low clears imm_out to 0 immediately (async), independent of clk.
//    Release takes effect at the next rising edge.
//  - imm_out holds 0 while rst_n stays low, regardless of clk, ins or imm_sel activity.
//  - Any X/unlisted value on imm_sel produces 0 (default branch). No latches.
//  - B and J immediates always have bit 0 = 0. U always has [11:0] = 0.
//  - Bits [31:5] of IMM_SH and bits [31:12] of IMM_IU are always 0, even when ins[31]=1.
// STRUCTURE
//  - Shared package immgen_pkg:
//    typedef enum logic [2:0] imm_sel_e {IMM_I, IMM_SH, IMM_IU, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}
//    XLEN/ILEN localparams.
//  - One natural sub-module: imm_extract. Purely combinational (ins, imm_sel -> imm_next).
//  - The top holds only the async-reset output register around imm_extract.
// TESTING
//  - Reset: assert rst_n=0 mid-cycle with ins=32'hFFFFFFFF, imm_sel=000 -> imm_out=0 immediately.
//    imm_out stays 0 until the first edge after release.
//  - ins=32'h12345678, imm_sel 000/001/010 -> imm_out 32'h00000123 / 32'h00000003 / 32'h00000123, one cycle later.
//  - ins=32'h12345678, imm_sel 011/100/101/110 -> 32'h0000012C / 32'h0000012C / 32'h12345000 / 32'h00045922.
//  - Negative sign: ins=32'hFFF00093 (addi -1), sel 000 -> 32'hFFFFFFFF.
//    Same ins, sel 010 -> 32'h00000FFF. sel 001 -> 32'h0000001F.
//  - B/J negative: ins=32'hFE000EE3 (beq offset -4), sel 100 -> 32'hFFFFFFFC.
//    ins=32'hFFDFF06F (jal -4), sel 110 -> 32'hFFFFFFFC.
//  - sel=111 with any ins -> 0.
//    Back-to-back sel changes every cycle: each result appears exactly one cycle after its input.

Source files
------------

// File: rtl/immgen_pkg.sv
// Shared types and widths for the RV32I immediate generator.
package immgen_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_SH   = 3'd1,
        IMM_IU   = 3'd2,
        IMM_S    = 3'd3,
        IMM_B    = 3'd4,
        IMM_U    = 3'd5,
        IMM_J    = 3'd6,
        IMM_NONE = 3'd7
    } imm_sel_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate field extraction and sign/zero extension.
module imm_extract
    import immgen_pkg::*;
(
    input  logic [ILEN-1:0] ins,
    input  logic [2:0]      imm_sel,
    output logic [XLEN-1:0] imm_next
);

    logic s;
    assign s = ins[ILEN-1];

    always_comb begin
        imm_next = '0;
        case (imm_sel)
            IMM_I:    imm_next = {{20{s}}, ins[31:20]};
            IMM_SH:   imm_next = {27'b0, ins[24:20]};
            IMM_IU:   imm_next = {20'b0, ins[31:20]};
            IMM_S:    imm_next = {{20{s}}, ins[31:25], ins[11:7]};
            IMM_B:    imm_next = {{19{s}}, s, ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:    imm_next = {ins[31:12], 12'b0};
            IMM_J:    imm_next = {{11{s}}, s, ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_NONE: imm_next = '0;
            // Unknown selects fall back to zero rather than propagating X.
            default:  imm_next = '0;
        endcase
    end

endmodule

// File: rtl/immediate_generator.sv
// Decode-stage immediate generator: extraction logic followed by one output register.
module immediate_generator
    import immgen_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ILEN-1:0] ins,
    input  logic [2:0]      imm_sel,
    output logic [XLEN-1:0] imm_out
);

    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] imm_q;

    imm_extract u_imm_extract (
        .ins      (ins),
        .imm_sel  (imm_sel),
        .imm_next (imm_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q <= '0;
        end else begin
            imm_q <= imm_d;
        end
    end

    assign imm_out = imm_q;

endmodule

// File: tb/tb_immediate_generator.sv
// Directed self-checking bench for immediate_generator.
module tb_immediate_generator;

    logic        clk;
    logic        rst_n;
    logic [31:0] ins;
    logic [2:0]  imm_sel;
    logic [31:0] imm_out;

    int n_checks;
    int n_fail;

    immediate_generator dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ins     (ins),
        .imm_sel (imm_sel),
        .imm_out (imm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        // Load a nonzero value first so the async clear is visible.
        rst_n   = 1'b1;
        ins     = 32'hFFFF_FFFF;
        imm_sel = 3'b000;
        @(posedge clk); #1;
        n_checks++;
        if (imm_out !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_preload: got %h expected %h", imm_out, 32'hFFFF_FFFF);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imm_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async_clear: got %h expected %h", imm_out, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ins     = ins ^ 32'h5A5A_5A5A;
            imm_sel = 3'(i);
            n_checks++;
            if (imm_out !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_hold_%0d: got %h expected %h", i, imm_out, 32'h0);
            end
        end
        ins     = 32'hFFFF_FFFF;
        imm_sel = 3'b000;
        #2;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imm_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release_pre_edge: got %h expected %h", imm_out, 32'h0);
        end
        @(posedge clk); #1;
        n_checks++;
        if (imm_out !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_release_post_edge: got %h expected %h", imm_out, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_positive_formats();
        logic [31:0] exp_tab [7];
        exp_tab = '{32'h0000_0123, 32'h0000_0003, 32'h0000_0123, 32'h0000_012C,
                    32'h0000_012C, 32'h1234_5000, 32'h0004_5922};
        ins = 32'h1234_5678;
        for (int i = 0; i < 7; i++) begin
            imm_sel = 3'(i);
            @(posedge clk); #1;
            n_checks++;
            if (imm_out !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL pos_sel%0d: got %h expected %h", i, imm_out, exp_tab[i]);
            end
        end
    endtask

    task automatic test_negative();
        logic [31:0] ins_tab [6];
        logic [2:0]  sel_tab [6];
        logic [31:0] exp_tab [6];
        ins_tab = '{32'hFFF0_0093, 32'hFFF0_0093, 32'hFFF0_0093,
                    32'hFE00_0EE3, 32'hFFDF_F06F, 32'hFFF0_0093};
        sel_tab = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b110, 3'b101};
        exp_tab = '{32'hFFFF_FFFF, 32'h0000_0FFF, 32'h0000_001F,
                    32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFF0_0000};
        for (int i = 0; i < 6; i++) begin
            ins     = ins_tab[i];
            imm_sel = sel_tab[i];
            @(posedge clk); #1;
            n_checks++;
            if (imm_out !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL neg_%0d ins=%h sel=%0d: got %h expected %h",
                         i, ins_tab[i], sel_tab[i], imm_out, exp_tab[i]);
            end
        end
    endtask

    task automatic test_none();
        logic [31:0] ins_tab [3];
        ins_tab = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0001};
        imm_sel = 3'b111;
        for (int i = 0; i < 3; i++) begin
            ins = ins_tab[i];
            @(posedge clk); #1;
            n_checks++;
            if (imm_out !== 32'h0) begin
                n_fail++;
                $display("FAIL none_%0d: got %h expected %h", i, imm_out, 32'h0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins_tab [6];
        logic [2:0]  sel_tab [6];
        logic [31:0] exp_tab [6];
        logic [31:0] prev;
        ins_tab = '{32'hFFF0_0093, 32'h1234_5678, 32'hFE00_0EE3,
                    32'h1234_5678, 32'hFFDF_F06F, 32'h1234_5678};
        sel_tab = '{3'b000, 3'b101, 3'b100, 3'b111, 3'b110, 3'b011};
        exp_tab = '{32'hFFFF_FFFF, 32'h1234_5000, 32'hFFFF_FFFC,
                    32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_012C};
        prev = imm_out;
        for (int i = 0; i < 6; i++) begin
            ins     = ins_tab[i];
            imm_sel = sel_tab[i];
            #1;
            // New inputs must not reach the output before the next edge.
            n_checks++;
            if (imm_out !== prev) begin
                n_fail++;
                $display("FAIL b2b_pre_%0d: got %h expected %h", i, imm_out, prev);
            end
            @(posedge clk); #1;
            n_checks++;
            if (imm_out !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL b2b_post_%0d: got %h expected %h", i, imm_out, exp_tab[i]);
            end
            prev = exp_tab[i];
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ins      = 32'h0;
        imm_sel  = 3'b111;
        #3;
        n_checks++;
        if (imm_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected %h", imm_out, 32'h0);
        end
        @(posedge clk); #1;
        test_reset();
        test_positive_formats();
        test_negative();
        test_none();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
